// File: rtl/bitstream_expander_64_pkg.sv
// rtl/bitstream_expander_64_pkg.sv - shared widths, LFSR constants and state type for bitstream_expander_64
package bitstream_expander_64_pkg;

    localparam int N       = 64;
    localparam int COUNT_W = 7;
    localparam int ACC_W   = 6;

    localparam logic [COUNT_W-1:0] N_COUNT   = 7'd64;
    localparam logic [ACC_W-1:0]   LFSR_SEED = 6'h01;
    // Feedback taps for x^6 + x^5 + 1
    localparam logic [ACC_W-1:0]   LFSR_TAPS = 6'b110000;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] c);
        return (c > N_COUNT) ? N_COUNT : c;
    endfunction

    function automatic logic [ACC_W-1:0] lfsr_next(input logic [ACC_W-1:0] s);
        return {s[ACC_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bitstream_expander_64_lfsr_6.sv
// rtl/bitstream_expander_64_lfsr_6.sv - 6-bit maximal LFSR, seeded on reset, steps when enabled
module lfsr_6
    import bitstream_expander_64_pkg::*;
(
    input  logic             CLK,
    input  logic             nRST,
    input  logic             enable,
    output logic [ACC_W-1:0] state
);

    logic [ACC_W-1:0] state_q;
    logic [ACC_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (enable) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/bitstream_expander_64.sv
// rtl/bitstream_expander_64.sv - re-serializes 0..64 popcounts into a 1-bit stochastic stream; DITHER_EN seeds the residue from an LFSR on clear
module bitstream_expander_64
    import bitstream_expander_64_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COUNT_W-1:0] count,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               bit_out,
    output logic [ACC_W-1:0]   residue,
    output logic               overflow_err
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             bit_q, bit_d;
    logic             err_q, err_d;

    logic               accept;
    logic               over_range;
    logic [COUNT_W-1:0] c_clamped;
    logic [COUNT_W-1:0] sum;
    logic [ACC_W-1:0]   clear_seed;

`ifdef DITHER_EN
    logic [ACC_W-1:0] lfsr_state;

    lfsr_6 u_lfsr (
        .CLK    (CLK),
        .nRST   (nRST),
        .enable (accept),
        .state  (lfsr_state)
    );

    assign clear_seed = lfsr_state;
`else
    assign clear_seed = '0;
`endif

    assign out_valid = (state_q == ST_FULL);
    // Ready never depends on in_valid, only on the output slot and clear
    assign in_ready  = !clear && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    always_comb begin
        over_range = (count > N_COUNT);
        c_clamped  = clamp_count(count);
        // 63 + 64 fits in 7 bits, so sum[6] is the single carry per sample
        sum        = {1'b0, acc_q} + c_clamped;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        bit_d   = bit_q;
        err_d   = err_q;
        if (clear) begin
            state_d = ST_EMPTY;
            acc_d   = clear_seed;
            bit_d   = 1'b0;
            err_d   = 1'b0;
        end else if (accept) begin
            state_d = ST_FULL;
            acc_d   = sum[ACC_W-1:0];
            bit_d   = sum[COUNT_W-1];
            err_d   = err_q | over_range;
        end else if (out_valid && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_EMPTY;
            acc_q   <= '0;
            bit_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            bit_q   <= bit_d;
            err_q   <= err_d;
        end
    end

    assign bit_out      = bit_q;
    assign residue      = acc_q;
    assign overflow_err = err_q;

endmodule

// File: tb/tb_bitstream_expander_64.sv
// tb/tb_bitstream_expander_64.sv - randomized and directed checks of bitstream_expander_64 against a cumulative-sum model
module tb_bitstream_expander_64;

    logic       CLK;
    logic       nRST;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] count;
    logic       out_valid;
    logic       out_ready;
    logic       bit_out;
    logic [5:0] residue;
    logic       overflow_err;

    bitstream_expander_64 dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .count        (count),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .bit_out      (bit_out),
        .residue      (residue),
        .overflow_err (overflow_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: total of clamped counts since clear; each output bit is the
    // number of whole multiples of 64 crossed by that sample.
    int m_total;
    int m_valid;
    int m_bit;
    int m_err;

    always @(posedge CLK or negedge nRST) begin
        int c;
        if (!nRST) begin
            m_total = 0; m_valid = 0; m_bit = 0; m_err = 0;
        end else if (clear) begin
            m_total = 0; m_valid = 0; m_bit = 0; m_err = 0;
        end else if (in_valid && (m_valid == 0 || out_ready)) begin
            c = (count > 64) ? 64 : int'(count);
            m_bit = ((m_total + c) / 64) - (m_total / 64);
            m_total = m_total + c;
            m_valid = 1;
            if (count > 64) m_err = 1;
        end else if (m_valid != 0 && out_ready) begin
            m_valid = 0;
        end
    end

    bit obs[$];
    always @(posedge CLK) begin
        if (nRST && out_valid && out_ready) obs.push_back(bit_out);
    end

    int n_cmp;
    int n_err;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ones_since(input int mark);
        int s = 0;
        for (int i = mark; i < obs.size(); i++) s += int'(obs[i]);
        return s;
    endfunction

    // One cycle: compare against the model at the falling edge, then step
    task automatic cyc();
        @(negedge CLK);
        chk("out_valid", int'(out_valid), m_valid);
        chk("in_ready", int'(in_ready), (!clear && (m_valid == 0 || out_ready)) ? 1 : 0);
        chk("overflow_err", int'(overflow_err), m_err);
        chk("residue", int'(residue), m_total % 64);
        if (m_valid != 0) chk("bit_out", int'(bit_out), m_bit);
        @(posedge CLK);
        #2;
    endtask

    task automatic stream(input int n, input int cnt);
        in_valid = 1'b1; count = 7'(cnt); out_ready = 1'b1;
        repeat (n) cyc();
        in_valid = 1'b0;
        cyc();
    endtask

    initial begin
        int mark;
        int b0, r0;
        n_cmp = 0; n_err = 0;
        nRST = 1'b0; clear = 1'b0; in_valid = 1'b0; count = '0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_residue", int'(residue), 0);
        chk("rst_err", int'(overflow_err), 0);
        chk("rst_bit", int'(bit_out), 0);
        @(posedge CLK); #2;
        nRST = 1'b1;
        cyc();

        mark = obs.size();
        stream(64, 32);
        chk("c32_n", obs.size() - mark, 64);
        chk("c32_ones", ones_since(mark), 32);
        chk("c32_b0", int'(obs[mark]), 0);
        chk("c32_b1", int'(obs[mark + 1]), 1);
        chk("c32_b63", int'(obs[mark + 63]), 1);
        chk("c32_res", int'(residue), 0);

        mark = obs.size();
        stream(16, 64);
        chk("c64_ones", ones_since(mark), 16);
        chk("c64_res", int'(residue), 0);
        mark = obs.size();
        stream(16, 0);
        chk("c0_ones", ones_since(mark), 0);
        chk("c0_n", obs.size() - mark, 16);
        chk("c64_0_err", int'(overflow_err), 0);

        mark = obs.size();
        stream(64, 21);
        chk("c21_ones", ones_since(mark), 21);
        chk("c21_res", int'(residue), 0);

        in_valid = 1'b1; count = 7'd100; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("ovf_bit", int'(bit_out), 1);
        chk("ovf_valid", int'(out_valid), 1);
        chk("ovf_err", int'(overflow_err), 1);
        chk("ovf_res", int'(residue), 0);
        repeat (4) cyc();
        chk("ovf_sticky", int'(overflow_err), 1);

        clear = 1'b1; cyc(); clear = 1'b0;
        chk("clr_err", int'(overflow_err), 0);
        mark = obs.size();
        in_valid = 1'b1; count = 7'd40; out_ready = 1'b0;
        cyc();
        count = 7'd30;
        b0 = int'(bit_out); r0 = int'(residue);
        chk("bp_res0", r0, 40);
        repeat (3) begin
            cyc();
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_bit", int'(bit_out), b0);
            chk("bp_res", int'(residue), r0);
            chk("bp_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("bp_n", obs.size() - mark, 2);
        chk("bp_ones", ones_since(mark), 1);
        chk("bp_res_end", int'(residue), 6);

        clear = 1'b1; cyc(); clear = 1'b0;
        in_valid = 1'b1; count = 7'd100; cyc();
        count = 7'd40; cyc();
        chk("pre_clr_res", int'(residue), 40);
        chk("pre_clr_err", int'(overflow_err), 1);
        clear = 1'b1; count = 7'd10; cyc();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_res", int'(residue), 0);
        chk("clr_valid", int'(out_valid), 0);
        chk("clr_err2", int'(overflow_err), 0);
        cyc();

        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom % 4) != 0;
            count     = 7'($urandom_range(0, 70));
            out_ready = ($urandom % 3) != 0;
            clear     = ($urandom % 97) == 0;
            nRST      = (i != 700);
            cyc();
        end
        nRST = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
